uart_rx_fifo_frontend: RTL and testbench
========================================

// Module: uart_rx_fifo_frontend
// PURPOSE
//  Parametrised serial UART receive front-end replacing the fixed 8N1 receiver at the PL ingest edge.
//  Provides: 2-FF synchroniser; fractional-accumulator oversample tick; majority-vote sampling.
//  Decodes configurable data/parity/stop framing; buffers bytes in a FIFO with valid/ready output.
//  Feeds the timestamp/parser core; reports framing, parity and overflow errors.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  fabric clock frequency
//  BAUD         115_200     line rate
//  OVERSAMPLE   16          samples per bit; even, >=8
//  DATA_BITS    8           5..9, LSB first
//  PARITY_MODE  0           0=none 1=even 2=odd
//  STOP_BITS    1           1 or 2
//  FIFO_DEPTH   16          power of 2, >=2
// PORTS
//  clk          in   1              PL clock
//  rst          in   1              synchronous active-high reset
//  rx_serial    in   1              asynchronous UART line, idle high
//  m_valid      out  1              FIFO head valid
//  m_ready      in   1              consumer accepts head when m_valid&&m_ready
//  m_data       out  DATA_BITS      FIFO head byte (first-word fall-through)
//  frame_err    out  1              1-cycle pulse: stop bit sampled low
//  parity_err   out  1              1-cycle pulse: parity mismatch
//  overflow     out  1              1-cycle pulse: byte dropped, FIFO full
//  drop_count   out  16             saturating count of overflow drops
//  fifo_level   out  $clog2(FIFO_DEPTH)+1   current occupancy
// BEHAVIOUR
//  Reset: m_valid=0, m_data=0, all error pulses=0, drop_count=0, fifo_level=0.
//   Synchroniser=1, accumulator=0, FSM=WAIT_IDLE.
//  Tick: 32-bit acc += BAUD*OVERSAMPLE each clk.
//   When acc >= CLK_FREQ_HZ: acc -= CLK_FREQ_HZ and tick=1 that cycle.
//   Gives exact long-run average rate.
//  Sampling: at tick index OS/2-1, OS/2, OS/2+1 within a bit, majority of 3 synced samples = bit value.
//  FSM states (advances on tick only):
//   WAIT_IDLE: stay until sampled line=1 for OS consecutive ticks; after reset and after frame error.
//   IDLE: falling edge (sync=0) -> START, tick counter cleared.
//   START: at mid-bit, vote=1 -> IDLE (glitch reject); vote=0 -> DATA at bit end.
//   DATA: shift LSB-first DATA_BITS bits -> PARITY if PARITY_MODE!=0, else STOP.
//   PARITY: compare vote with even/odd parity of data -> STOP.
//   STOP: each stop bit checked at mid-bit. Any low stop -> frame_err pulse, byte discarded, -> WAIT_IDLE.
//    Otherwise, at mid-bit of last stop: parity bad -> parity_err pulse, byte discarded, -> IDLE.
//    Otherwise push byte, -> IDLE (no wait for bit end, allows back-to-back frames).
//  Push latency: byte written the cycle after last-stop mid-bit sample.
//   m_valid=1 on next clk when FIFO was empty.
//  FIFO: pop when m_valid&&m_ready.
//   Push when full: byte dropped, overflow pulse, drop_count+1 saturating at 16'hFFFF.
//   Push and pop same cycle when full: pop frees slot, push accepted, no overflow.
//   Push and pop same cycle when empty: no bypass; byte appears next cycle.
//   m_data stable while m_valid && !m_ready.
//  Error pulses mutually exclusive per frame; a frame emits at most one of push/frame_err/parity_err/overflow.
//  rst mid-frame: partial byte and FIFO contents lost; next valid frame after line idle is received intact.
// STRUCTURE
//  uart_rx_pkg: rx_state_e (WAIT_IDLE,IDLE,START,DATA,PARITY,STOP).
//   Also PARITY_NONE/EVEN/ODD constants and the function computing tick-acc width.
//  Sub-module sync_fifo #(WIDTH,DEPTH): FWFT FIFO, full/empty/level, simultaneous push/pop rules above.
//  Top holds synchroniser, tick generator, sampler, FSM, error/counter logic.
// TESTING
//  1) Byte 0x55 8N1 at 115200: m_data=0x55, m_valid=1, fifo_level=1, no error pulses.
//  2) Stop bit held low, then line high 1 bit time, then 0xA3: frame_err once, nothing stored; 0xA3 received.
//  3) m_ready=0, 17 bytes, depth 16: level=16, overflow once, drop_count=1; draining yields 16 bytes in order.
//  4) 1 us low glitch on idle line: no start, no pulses, level stays 0.
//  5) PARITY_MODE=1, 0x0F with parity bit 1 (wrong): parity_err once, byte dropped; correct parity 0 -> stored.
//  6) rst pulse mid-byte, line released: level=0, m_valid=0; next 0x7E received correctly.
//  Plus: BAUD=921600 stream of 256 random bytes back-to-back, m_ready random: all bytes in order, zero errors.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive front-end.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Width of the fractional tick accumulator: wide enough to hold
  // clk_freq + step without wrapping, never narrower than 32 bits.
  function automatic int tick_acc_width(input longint clk_freq_hz, input longint step);
    longint max_sum;
    int     w;
    max_sum = clk_freq_hz + step;
    w = $clog2(max_sum + 1);
    return (w < 32) ? 32 : w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_frontend_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy level.
// A pop frees a slot in the same cycle, so a push against a full FIFO is
// accepted when a pop happens alongside it. There is no empty bypass.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == FULL_LVL);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Head word is held at zero while empty so the output is defined out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_frontend.sv
// uart_rx_fifo_frontend: oversampling UART receiver with configurable
// data/parity/stop framing, feeding a FWFT FIFO with error reporting.
//
// Output handshake: a word transfers on every rising clk edge where
// m_valid && m_ready are both high; m_valid never drops and m_data never
// changes while a word is offered and not yet taken.
module uart_rx_fifo_frontend
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_serial,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int ACC_W = tick_acc_width(longint'(CLK_FREQ_HZ),
                                        longint'(BAUD) * longint'(OVERSAMPLE));
  localparam logic [ACC_W-1:0] ACC_STEP = ACC_W'(longint'(BAUD) * longint'(OVERSAMPLE));
  localparam logic [ACC_W-1:0] ACC_MOD  = ACC_W'(CLK_FREQ_HZ);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] MID_LO    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] MID_C     = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] MID_HI    = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_sum;
  logic                 tick;
  logic [1:0]           samp_q;
  logic                 vote;
  logic                 at_mid;
  logic                 at_end;
  logic                 exp_par;

  rx_state_e            state, state_n;
  logic [OS_W-1:0]      os_cnt, os_cnt_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bad, par_bad_n;
  logic                 push_n, frame_err_n, parity_err_n;
  logic                 push_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_drop;

  assign rx_s    = sync_q[1];
  assign acc_sum = acc + ACC_STEP;
  // Third sample is the live synchronised line at the MID_HI tick.
  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign at_mid  = (os_cnt == MID_HI);
  assign at_end  = (os_cnt == OS_LAST);
  assign exp_par = (PARITY_MODE == PARITY_ODD) ? ~^shreg : ^shreg;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_serial};
  end

  // Fractional accumulator: one tick per wrap past the clock frequency.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (acc_sum >= ACC_MOD) begin
      acc  <= acc_sum - ACC_MOD;
      tick <= 1'b1;
    end else begin
      acc  <= acc_sum;
      tick <= 1'b0;
    end
  end

  // Capture the two early mid-bit samples used by the majority vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= 2'b11;
    end else if (tick) begin
      if (os_cnt == MID_LO) samp_q[0] <= rx_s;
      if (os_cnt == MID_C)  samp_q[1] <= rx_s;
    end
  end

  // Receive FSM state and datapath registers, plus registered event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      push_q     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      os_cnt     <= os_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_bad    <= par_bad_n;
      push_q     <= push_n;
      frame_err  <= frame_err_n;
      parity_err <= parity_err_n;
    end
  end

  // Next-state logic; everything advances on oversample ticks only.
  always_comb begin
    state_n      = state;
    os_cnt_n     = os_cnt;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    par_bad_n    = par_bad;
    push_n       = 1'b0;
    frame_err_n  = 1'b0;
    parity_err_n = 1'b0;
    if (tick) begin
      os_cnt_n = os_cnt + 1'b1;
      case (state)
        // os_cnt counts consecutive high ticks here.
        WAIT_IDLE: begin
          if (!rx_s) begin
            os_cnt_n = '0;
          end else if (at_end) begin
            state_n  = IDLE;
            os_cnt_n = '0;
          end
        end
        // The detecting tick is index 0 of the start bit.
        IDLE: begin
          if (!rx_s) begin
            state_n  = START;
            os_cnt_n = OS_W'(1);
          end else begin
            os_cnt_n = '0;
          end
        end
        START: begin
          if (at_mid && vote) begin
            state_n  = IDLE;
            os_cnt_n = '0;
          end else if (at_end) begin
            state_n   = DATA;
            os_cnt_n  = '0;
            bit_cnt_n = '0;
            par_bad_n = 1'b0;
          end
        end
        DATA: begin
          if (at_mid) shreg_n = {vote, shreg[DATA_BITS-1:1]};
          if (at_end) begin
            os_cnt_n = '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt_n = '0;
              state_n   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (at_mid) par_bad_n = (vote != exp_par);
          if (at_end) begin
            state_n  = STOP;
            os_cnt_n = '0;
          end
        end
        // The last stop bit is resolved at mid-bit so a following start
        // edge is caught even when frames are sent back to back.
        STOP: begin
          if (at_mid) begin
            if (!vote) begin
              frame_err_n = 1'b1;
              state_n     = WAIT_IDLE;
              os_cnt_n    = '0;
            end else if (bit_cnt == STOP_LAST) begin
              if (par_bad) parity_err_n = 1'b1;
              else         push_n       = 1'b1;
              state_n  = IDLE;
              os_cnt_n = '0;
            end
          end else if (at_end) begin
            os_cnt_n  = '0;
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        default: begin
          state_n  = WAIT_IDLE;
          os_cnt_n = '0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (shreg),
    .pop       (m_ready),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign m_valid   = !fifo_empty;
  // A full FIFO is never empty, so m_ready alone means a pop is freeing a slot.
  assign fifo_drop = push_q && fifo_full && !m_ready;

  // Overflow pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= fifo_drop;
      if (fifo_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_frontend.sv
// Bench for uart_rx_fifo_frontend: three instances (8N1 115200, 8E1 115200,
// 8N1 921600) share one 16 MHz clock; serial frames are built from the
// framing rules and driven in real time.
`timescale 1ns/1ps
module tb_uart_rx_fifo_frontend;

  localparam int  F_CLK    = 16_000_000;
  localparam real CLK_HALF = 31.25;
  localparam real BIT_S    = 1.0e9 / 115200.0;
  localparam real BIT_F    = 1.0e9 / 921600.0;

  int checks = 0;
  int passed = 0;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #(CLK_HALF) clk = ~clk;

  // ---------------- DUT signals (d: 8N1, p: 8E1, f: fast 8N1) ----------------
  logic       rst_d, rx_d, mr_d, mv_d, fe_d, pe_d, ov_d;
  logic [7:0] md_d;
  logic [15:0] dc_d;
  logic [4:0] lvl_d;
  logic       rst_p, rx_p, mr_p, mv_p, fe_p, pe_p, ov_p;
  logic [7:0] md_p;
  logic [15:0] dc_p;
  logic [4:0] lvl_p;
  logic       rst_f, rx_f, mr_f, mv_f, fe_f, pe_f, ov_f;
  logic [7:0] md_f;
  logic [15:0] dc_f;
  logic [4:0] lvl_f;

  uart_rx_fifo_frontend #(.CLK_FREQ_HZ(F_CLK), .BAUD(115200)) dut_d (
    .clk(clk), .rst(rst_d), .rx_serial(rx_d), .m_valid(mv_d), .m_ready(mr_d),
    .m_data(md_d), .frame_err(fe_d), .parity_err(pe_d), .overflow(ov_d),
    .drop_count(dc_d), .fifo_level(lvl_d));

  uart_rx_fifo_frontend #(.CLK_FREQ_HZ(F_CLK), .BAUD(115200), .PARITY_MODE(1)) dut_p (
    .clk(clk), .rst(rst_p), .rx_serial(rx_p), .m_valid(mv_p), .m_ready(mr_p),
    .m_data(md_p), .frame_err(fe_p), .parity_err(pe_p), .overflow(ov_p),
    .drop_count(dc_p), .fifo_level(lvl_p));

  uart_rx_fifo_frontend #(.CLK_FREQ_HZ(F_CLK), .BAUD(921600)) dut_f (
    .clk(clk), .rst(rst_f), .rx_serial(rx_f), .m_valid(mv_f), .m_ready(mr_f),
    .m_data(md_f), .frame_err(fe_f), .parity_err(pe_f), .overflow(ov_f),
    .drop_count(dc_f), .fifo_level(lvl_f));

  // ---------------- pulse counters (cycles high), index 0=d 1=p 2=f ----------------
  int n_fe[3];
  int n_pe[3];
  int n_ov[3];
  initial begin
    for (int i = 0; i < 3; i++) begin
      n_fe[i] = 0; n_pe[i] = 0; n_ov[i] = 0;
    end
  end
  always @(negedge clk) begin
    n_fe[0] += int'(fe_d); n_pe[0] += int'(pe_d); n_ov[0] += int'(ov_d);
    n_fe[1] += int'(fe_p); n_pe[1] += int'(pe_p); n_ov[1] += int'(ov_p);
    n_fe[2] += int'(fe_f); n_pe[2] += int'(pe_f); n_ov[2] += int'(ov_f);
  end

  // ---------------- driver tasks ----------------
  task automatic set_line(input int which, input logic v);
    case (which)
      0: rx_d = v;
      1: rx_p = v;
      default: rx_f = v;
    endcase
  endtask

  // Build a frame from the framing rules: start 0, data LSB first,
  // optional parity (1=even, 2=odd, optionally inverted), one stop bit.
  task automatic send_frame(input int which, input logic [7:0] data, input int par_mode,
                            input logic par_flip, input logic stop_low, input real bit_ns);
    logic [11:0] bits;
    int n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = data[i]; n++;
    end
    if (par_mode != 0) begin
      bits[n] = ((par_mode == 2) ? ~^data : ^data) ^ par_flip; n++;
    end
    bits[n] = ~stop_low; n++;
    for (int i = 0; i < n; i++) begin
      set_line(which, bits[i]);
      #(bit_ns);
    end
  endtask

  task automatic pop_one_d();
    @(posedge clk); #1 mr_d = 1'b1;
    @(posedge clk); #1 mr_d = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_d = 1'b1; rst_p = 1'b1; rst_f = 1'b1;
    rx_d = 1'b1; rx_p = 1'b1; rx_f = 1'b1;
    mr_d = 1'b0; mr_p = 1'b0; mr_f = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_d = 1'b0; rst_p = 1'b0; rst_f = 1'b0;
    @(negedge clk);
    checks++; if (mv_d !== 1'b0) $display("FAIL rst_m_valid got %b exp 0", mv_d); else passed++;
    checks++; if (md_d !== 8'h00) $display("FAIL rst_m_data got %h exp 00", md_d); else passed++;
    checks++; if (lvl_d !== 5'd0) $display("FAIL rst_level got %0d exp 0", lvl_d); else passed++;
    checks++; if (dc_d !== 16'd0) $display("FAIL rst_drop_count got %0d exp 0", dc_d); else passed++;
    checks++; if ({fe_d, pe_d, ov_d} !== 3'b000) $display("FAIL rst_pulses got %b exp 000", {fe_d, pe_d, ov_d}); else passed++;
    checks++; if ({mv_p, mv_f} !== 2'b00) $display("FAIL rst_valid_pf got %b exp 00", {mv_p, mv_f}); else passed++;
    #(BIT_S * 2.0);
  endtask

  task automatic test_basic();
    int fe0, pe0, ov0;
    fe0 = n_fe[0]; pe0 = n_pe[0]; ov0 = n_ov[0];
    send_frame(0, 8'h55, 0, 1'b0, 1'b0, BIT_S);
    repeat (2) @(negedge clk);
    checks++; if (mv_d !== 1'b1) $display("FAIL t1_m_valid got %b exp 1", mv_d); else passed++;
    checks++; if (md_d !== 8'h55) $display("FAIL t1_m_data got %h exp 55", md_d); else passed++;
    checks++; if (lvl_d !== 5'd1) $display("FAIL t1_level got %0d exp 1", lvl_d); else passed++;
    checks++; if ((n_fe[0] - fe0) + (n_pe[0] - pe0) + (n_ov[0] - ov0) !== 0)
      $display("FAIL t1_err_pulses got %0d exp 0", (n_fe[0] - fe0) + (n_pe[0] - pe0) + (n_ov[0] - ov0));
    else passed++;
    pop_one_d();
    @(negedge clk);
    checks++; if (lvl_d !== 5'd0) $display("FAIL t1_level_after_pop got %0d exp 0", lvl_d); else passed++;
  endtask

  task automatic test_frame_error();
    int fe0;
    fe0 = n_fe[0];
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1, BIT_S);
    rx_d = 1'b1;
    @(negedge clk);
    checks++; if (n_fe[0] - fe0 !== 1) $display("FAIL t2_frame_err got %0d exp 1", n_fe[0] - fe0); else passed++;
    checks++; if (lvl_d !== 5'd0) $display("FAIL t2_nothing_stored got %0d exp 0", lvl_d); else passed++;
    // One bit time of idle, with a quarter-bit margin for tick phase.
    #(BIT_S * 1.25);
    send_frame(0, 8'hA3, 0, 1'b0, 1'b0, BIT_S);
    repeat (2) @(negedge clk);
    checks++; if (lvl_d !== 5'd1) $display("FAIL t2_level got %0d exp 1", lvl_d); else passed++;
    checks++; if (md_d !== 8'hA3) $display("FAIL t2_m_data got %h exp a3", md_d); else passed++;
    checks++; if (n_fe[0] - fe0 !== 1) $display("FAIL t2_frame_err_total got %0d exp 1", n_fe[0] - fe0); else passed++;
    pop_one_d();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int ov0;
    ov0 = n_ov[0];
    mr_d = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 16) exp_q.push_back(b);
      send_frame(0, b, 0, 1'b0, 1'b0, BIT_S);
    end
    repeat (4) @(negedge clk);
    checks++; if (lvl_d !== 5'd16) $display("FAIL t3_level got %0d exp 16", lvl_d); else passed++;
    checks++; if (n_ov[0] - ov0 !== 1) $display("FAIL t3_overflow got %0d exp 1", n_ov[0] - ov0); else passed++;
    checks++; if (dc_d !== 16'd1) $display("FAIL t3_drop_count got %0d exp 1", dc_d); else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mv_d !== 1'b1 || md_d !== exp_q[0]) $display("FAIL t3_drain_%0d got %b/%h exp 1/%h", i, mv_d, md_d, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      pop_one_d();
      @(negedge clk);
    end
    checks++; if ({mv_d, lvl_d} !== 6'd0) $display("FAIL t3_empty got %b/%0d exp 0/0", mv_d, lvl_d); else passed++;
  endtask

  task automatic test_glitch();
    int fe0, pe0, ov0;
    fe0 = n_fe[0]; pe0 = n_pe[0]; ov0 = n_ov[0];
    rx_d = 1'b0;
    #1000;
    rx_d = 1'b1;
    #(BIT_S * 2.0);
    checks++; if (lvl_d !== 5'd0 || mv_d !== 1'b0) $display("FAIL t4_level got %0d/%b exp 0/0", lvl_d, mv_d); else passed++;
    checks++; if ((n_fe[0] - fe0) + (n_pe[0] - pe0) + (n_ov[0] - ov0) !== 0)
      $display("FAIL t4_pulses got %0d exp 0", (n_fe[0] - fe0) + (n_pe[0] - pe0) + (n_ov[0] - ov0));
    else passed++;
  endtask

  task automatic test_parity();
    int pe0, fe0;
    pe0 = n_pe[1]; fe0 = n_fe[1];
    send_frame(1, 8'h0F, 1, 1'b1, 1'b0, BIT_S);
    repeat (2) @(negedge clk);
    checks++; if (n_pe[1] - pe0 !== 1) $display("FAIL t5_parity_err got %0d exp 1", n_pe[1] - pe0); else passed++;
    checks++; if (lvl_p !== 5'd0) $display("FAIL t5_dropped got %0d exp 0", lvl_p); else passed++;
    send_frame(1, 8'h0F, 1, 1'b0, 1'b0, BIT_S);
    send_frame(1, 8'h07, 1, 1'b0, 1'b0, BIT_S);
    repeat (2) @(negedge clk);
    checks++; if (lvl_p !== 5'd2) $display("FAIL t5_level got %0d exp 2", lvl_p); else passed++;
    checks++; if (md_p !== 8'h0F) $display("FAIL t5_m_data got %h exp 0f", md_p); else passed++;
    checks++; if (n_pe[1] - pe0 !== 1 || n_fe[1] - fe0 !== 0)
      $display("FAIL t5_err_totals got %0d/%0d exp 1/0", n_pe[1] - pe0, n_fe[1] - fe0);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int fe0, pe0;
    send_frame(0, 8'h11, 0, 1'b0, 1'b0, BIT_S);
    rx_d = 1'b0;
    #(BIT_S * 3.5);
    @(posedge clk); #1 rst_d = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_d = 1'b0;
    rx_d = 1'b1;
    #(BIT_S * 2.0);
    @(negedge clk);
    checks++; if (lvl_d !== 5'd0 || mv_d !== 1'b0) $display("FAIL t6_cleared got %0d/%b exp 0/0", lvl_d, mv_d); else passed++;
    checks++; if (dc_d !== 16'd0) $display("FAIL t6_drop_count got %0d exp 0", dc_d); else passed++;
    fe0 = n_fe[0]; pe0 = n_pe[0];
    send_frame(0, 8'h7E, 0, 1'b0, 1'b0, BIT_S);
    repeat (2) @(negedge clk);
    checks++; if (lvl_d !== 5'd1 || md_d !== 8'h7E) $display("FAIL t6_rx got %0d/%h exp 1/7e", lvl_d, md_d); else passed++;
    checks++; if (n_fe[0] - fe0 + n_pe[0] - pe0 !== 0) $display("FAIL t6_pulses got %0d exp 0", n_fe[0] - fe0 + n_pe[0] - pe0); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int got;
    int budget;
    bit done;
    got = 0;
    budget = 0;
    done = 1'b0;
    fork
      begin
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
          b = 8'($urandom_range(0, 255));
          exp_q.push_back(b);
          send_frame(2, b, 0, 1'b0, 1'b0, BIT_F);
        end
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 mr_f = 1'($urandom_range(0, 1));
        end
        mr_f = 1'b0;
      end
      begin
        while (got < 256 && budget < 70000) begin
          @(negedge clk);
          budget++;
          if (mv_f && mr_f) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL stream_extra got %h exp none", md_f);
            else if (md_f !== exp_q[0]) $display("FAIL stream_byte_%0d got %h exp %h", got, md_f, exp_q[0]);
            else passed++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
          end
        end
        done = 1'b1;
      end
    join
    checks++; if (got !== 256) $display("FAIL stream_count got %0d exp 256", got); else passed++;
    checks++; if (n_fe[2] + n_pe[2] + n_ov[2] !== 0)
      $display("FAIL stream_errors got %0d exp 0", n_fe[2] + n_pe[2] + n_ov[2]);
    else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    fork
      test_back_to_back();
      begin
        test_basic();
        test_frame_error();
        test_overflow();
        test_glitch();
        test_parity();
        test_reset_mid_frame();
      end
    join
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #6_000_000;
    $display("FAIL watchdog got timeout exp completion (%0d/%0d so far)", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
